// File: rtl/tick_divider.sv
// tick_divider: multi-channel fractional tick generator.
// Each channel is a phase accumulator: acc advances by inc every clock and
// wraps modulo mod. Every wrap produces a one-cycle tick and toggles a level
// output, so the average tick rate is exactly clk*inc/mod with no drift.
// One configuration write per cycle loads, restarts or disables one channel.
//
// Configuration handshake: i_cfg_valid is a single-cycle strobe with no
// back-pressure. Each cycle it is high, exactly one write is sampled at the
// rising edge. An accepted write takes effect at that edge. A rejected write
// changes no channel state and raises o_cfg_error for the following cycle.
module tick_divider #(
    parameter int channels   = 2,
    parameter int acc_width  = 32,
    parameter int chan_width = (channels > 1) ? $clog2(channels) : 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_cfg_valid,
    input  logic [chan_width-1:0] i_cfg_chan,
    input  logic                  i_cfg_en,
    input  logic [acc_width-1:0]  i_cfg_inc,
    input  logic [acc_width-1:0]  i_cfg_mod,
    output logic                  o_cfg_error,
    output logic [channels-1:0]   o_tick,
    output logic [channels-1:0]   o_level,
    output logic [channels-1:0]   o_active
);

    // One-hot channel decode; an index with no matching channel stays all-zero.
    logic [channels-1:0] w_sel;
    logic                w_chan_ok;
    logic                w_params_ok;
    logic                w_write_ok;
    logic [channels-1:0] w_load;
    logic                r_cfg_error;

    // Decode the target channel of the configuration write.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < channels; i++) begin
            w_sel[i] = (i_cfg_chan == chan_width'(i));
        end
    end

    // A disable is always legal; an enable needs 0 < inc <= mod.
    assign w_chan_ok   = |w_sel;
    assign w_params_ok = !i_cfg_en ||
                         ((i_cfg_mod != '0) && (i_cfg_inc != '0) && (i_cfg_inc <= i_cfg_mod));
    assign w_write_ok  = i_cfg_valid && w_chan_ok && w_params_ok;
    assign w_load      = w_sel & {channels{w_write_ok}};

    // Registered one-cycle error pulse for a rejected write.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cfg_error <= 1'b0;
        end else begin
            r_cfg_error <= i_cfg_valid && !(w_chan_ok && w_params_ok);
        end
    end

    assign o_cfg_error = r_cfg_error;

    for (genvar g = 0; g < channels; g++) begin : g_chan
        logic [acc_width-1:0] r_acc;
        logic [acc_width-1:0] r_inc;
        logic [acc_width-1:0] r_mod;
        logic                 r_en;
        logic                 r_tick;
        logic                 r_level;
        logic [acc_width:0]   w_sum;
        logic [acc_width-1:0] w_wrapped;
        logic                 w_wrap;

        // The sum is one bit wider so that acc + inc never overflows. When
        // wrapping, the result is below mod, so the modular W-bit
        // subtraction is exact.
        assign w_sum     = {1'b0, r_acc} + {1'b0, r_inc};
        assign w_wrap    = (w_sum >= {1'b0, r_mod});
        assign w_wrapped = r_acc + r_inc - r_mod;

        // Channel state: a write wins over accumulation (phase restart or
        // disable); otherwise an enabled channel accumulates and ticks on wrap.
        always_ff @(posedge i_clock or posedge i_reset) begin
            if (i_reset) begin
                r_acc   <= '0;
                r_inc   <= '0;
                r_mod   <= '0;
                r_en    <= 1'b0;
                r_tick  <= 1'b0;
                r_level <= 1'b0;
            end else if (w_load[g]) begin
                if (i_cfg_en) begin
                    r_inc <= i_cfg_inc;
                    r_mod <= i_cfg_mod;
                end
                r_en    <= i_cfg_en;
                r_acc   <= '0;
                r_tick  <= 1'b0;
                r_level <= 1'b0;
            end else if (r_en) begin
                if (w_wrap) begin
                    r_acc   <= w_wrapped;
                    r_tick  <= 1'b1;
                    r_level <= ~r_level;
                end else begin
                    r_acc   <= w_sum[acc_width-1:0];
                    r_tick  <= 1'b0;
                end
            end else begin
                r_acc  <= '0;
                r_tick <= 1'b0;
            end
        end

        assign o_tick[g]   = r_tick;
        assign o_level[g]  = r_level;
        assign o_active[g] = r_en;
    end

endmodule

// File: tb/tb_tick_divider.sv
// Directed testbench for tick_divider (3 channels so that an out-of-range
// channel index is encodable on the 2-bit cfg_chan).
// Inputs change and outputs are sampled on the falling edge; "after edge N"
// means the falling edge following rising edge N.
module tb_tick_divider;

    localparam int CH = 3;
    localparam int W  = 32;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic [CW-1:0] chan;
    logic          en;
    logic [W-1:0]  inc;
    logic [W-1:0]  mod_v;
    logic          err;
    logic [CH-1:0] tick;
    logic [CH-1:0] level;
    logic [CH-1:0] active;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tick_divider #(
        .channels  (CH),
        .acc_width (W),
        .chan_width(CW)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_cfg_valid(valid),
        .i_cfg_chan (chan),
        .i_cfg_en   (en),
        .i_cfg_inc  (inc),
        .i_cfg_mod  (mod_v),
        .o_cfg_error(err),
        .o_tick     (tick),
        .o_level    (level),
        .o_active   (active)
    );

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        chan  = '0;
        en    = 1'b0;
        inc   = '0;
        mod_v = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One write sampled at the next rising edge; returns after that edge.
    task automatic write_cfg(input logic [CW-1:0] c, input logic e,
                             input logic [W-1:0] i_v, input logic [W-1:0] m_v);
        chan  = c;
        en    = e;
        inc   = i_v;
        mod_v = m_v;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; chan = '0; en = 1'b0; inc = '0; mod_v = '0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (tick !== 3'b000)   begin errors++; $display("FAIL reset_tick got %b exp 000", tick); end
        checks++; if (level !== 3'b000)  begin errors++; $display("FAIL reset_level got %b exp 000", level); end
        checks++; if (active !== 3'b000) begin errors++; $display("FAIL reset_active got %b exp 000", active); end
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        rst = 1'b0;
        write_cfg(2'd0, 1'b1, 32'd3, 32'd10);
        for (int j = 1; j <= 4; j++) idle();
        checks++; if (tick !== 3'b001)   begin errors++; $display("FAIL pre_reset_tick got %b exp 001", tick); end
        checks++; if (level !== 3'b001)  begin errors++; $display("FAIL pre_reset_level got %b exp 001", level); end
        // Mid-cycle asynchronous reset: outputs must clear before any clock edge.
        #2 rst = 1'b1;
        #1;
        checks++; if (tick !== 3'b000)   begin errors++; $display("FAIL async_reset_tick got %b exp 000", tick); end
        checks++; if (level !== 3'b000)  begin errors++; $display("FAIL async_reset_level got %b exp 000", level); end
        checks++; if (active !== 3'b000) begin errors++; $display("FAIL async_reset_active got %b exp 000", active); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fractional();
        logic [20:0] mask;
        logic        exp_lv;
        mask = '0;
        mask[4] = 1'b1; mask[7] = 1'b1; mask[10] = 1'b1;
        mask[14] = 1'b1; mask[17] = 1'b1; mask[20] = 1'b1;
        exp_lv = 1'b0;
        do_reset();
        write_cfg(2'd0, 1'b1, 32'd3, 32'd10);
        checks++; if (active !== 3'b001) begin errors++; $display("FAIL frac_active got %b exp 001", active); end
        for (int j = 1; j <= 20; j++) begin
            idle();
            if (mask[j]) exp_lv = ~exp_lv;
            checks++;
            if (tick !== {2'b00, mask[j]}) begin
                errors++; $display("FAIL frac_tick j=%0d got %b exp %b", j, tick, {2'b00, mask[j]});
            end
            checks++;
            if (level[0] !== exp_lv) begin
                errors++; $display("FAIL frac_level j=%0d got %b exp %b", j, level[0], exp_lv);
            end
        end
    endtask

    task automatic test_baud();
        int cnt;
        int last;
        cnt = 0; last = 0;
        do_reset();
        write_cfg(2'd1, 1'b1, 32'd9, 32'd2000);
        for (int j = 1; j <= 4000; j++) begin
            idle();
            if (tick[1] === 1'b1) begin
                cnt++;
                checks++;
                if (last == 0) begin
                    if (j != 223) begin errors++; $display("FAIL baud_first j got %0d exp 223", j); end
                end else if ((j - last) != 222 && (j - last) != 223) begin
                    errors++; $display("FAIL baud_spacing got %0d exp 222 or 223", j - last);
                end
                last = j;
            end
            if (j == 2000) begin
                checks++; if (cnt != 9) begin errors++; $display("FAIL baud_window1 got %0d exp 9", cnt); end
            end
        end
        checks++; if (cnt != 18) begin errors++; $display("FAIL baud_window2 got %0d exp 18", cnt); end
        checks++; if (tick[0] !== 1'b0) begin errors++; $display("FAIL baud_idle_ch0 got %b exp 0", tick[0]); end
    endtask

    task automatic test_rtc();
        int cnt0;
        int cnt1;
        int last;
        cnt0 = 0; cnt1 = 0; last = 0;
        do_reset();
        write_cfg(2'd1, 1'b1, 32'd1, 32'd1);
        write_cfg(2'd0, 1'b1, 32'd65536, 32'd25000000);
        for (int j = 1; j <= 3000; j++) begin
            idle();
            if (tick[1] === 1'b1) cnt1++;
            if (tick[0] === 1'b1) begin
                cnt0++;
                checks++;
                if (last == 0) begin
                    if (j != 382 || level[0] !== 1'b1) begin
                        errors++; $display("FAIL rtc_first j got %0d level %b exp 382 level 1", j, level[0]);
                    end
                end else if ((j - last) != 381 && (j - last) != 382) begin
                    errors++; $display("FAIL rtc_spacing got %0d exp 381 or 382", j - last);
                end
                last = j;
            end
        end
        checks++; if (cnt0 != 7)    begin errors++; $display("FAIL rtc_count got %0d exp 7", cnt0); end
        checks++; if (level[0] !== 1'b1) begin errors++; $display("FAIL rtc_level got %b exp 1", level[0]); end
        checks++; if (cnt1 != 3000) begin errors++; $display("FAIL rtc_ch1_count got %0d exp 3000", cnt1); end
    endtask

    task automatic test_errors();
        do_reset();
        write_cfg(2'd0, 1'b1, 32'd3, 32'd10);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_good_write got %b exp 0", err); end
        write_cfg(2'd3, 1'b1, 32'd1, 32'd2);    // j=1 channel out of range
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_chan got %b exp 1", err); end
        write_cfg(2'd0, 1'b1, 32'd5, 32'd4);    // j=2 inc > mod
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_inc_gt_mod got %b exp 1", err); end
        write_cfg(2'd1, 1'b1, 32'd5, 32'd0);    // j=3 mod == 0
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_mod_zero got %b exp 1", err); end
        checks++; if (tick !== 3'b000) begin errors++; $display("FAIL err_tick_j3 got %b exp 000", tick); end
        idle();                                 // j=4 first tick of ch0
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err); end
        checks++; if (tick !== 3'b001) begin errors++; $display("FAIL err_tick_j4 got %b exp 001", tick); end
        write_cfg(2'd2, 1'b0, 32'd0, 32'd0);    // j=5 disable with zero params is legal
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_disable got %b exp 0", err); end
        idle();                                 // j=6
        idle();                                 // j=7 second tick
        checks++; if (tick !== 3'b001) begin errors++; $display("FAIL err_tick_j7 got %b exp 001", tick); end
        checks++; if (active !== 3'b001) begin errors++; $display("FAIL err_active got %b exp 001", active); end
        write_cfg(2'd0, 1'b1, 32'd0, 32'd4);    // j=8 inc == 0
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_inc_zero got %b exp 1", err); end
        idle(); idle();                         // j=10 third tick
        checks++; if (tick !== 3'b001) begin errors++; $display("FAIL err_tick_j10 got %b exp 001", tick); end
    endtask

    task automatic test_collision();
        do_reset();
        write_cfg(2'd1, 1'b1, 32'd1, 32'd1);
        write_cfg(2'd0, 1'b1, 32'd3, 32'd10);
        idle(); idle(); idle();                 // acc = 9
        write_cfg(2'd0, 1'b1, 32'd3, 32'd10);   // would have wrapped here
        checks++; if (tick !== 3'b010) begin errors++; $display("FAIL coll_tick got %b exp 010", tick); end
        checks++; if (level[0] !== 1'b0) begin errors++; $display("FAIL coll_level got %b exp 0", level[0]); end
        for (int j = 1; j <= 3; j++) begin
            idle();
            checks++; if (tick !== 3'b010) begin errors++; $display("FAIL coll_quiet j=%0d got %b exp 010", j, tick); end
        end
        idle();
        checks++; if (tick !== 3'b011) begin errors++; $display("FAIL coll_restart_tick got %b exp 011", tick); end
        checks++; if (level[0] !== 1'b1) begin errors++; $display("FAIL coll_restart_level got %b exp 1", level[0]); end
        write_cfg(2'd0, 1'b0, 32'd0, 32'd0);
        checks++; if (active !== 3'b010) begin errors++; $display("FAIL dis_active got %b exp 010", active); end
        checks++; if (level[0] !== 1'b0) begin errors++; $display("FAIL dis_level got %b exp 0", level[0]); end
        for (int j = 1; j <= 15; j++) begin
            idle();
            checks++;
            if (tick !== 3'b010 || level[0] !== 1'b0) begin
                errors++; $display("FAIL dis_quiet j=%0d got tick %b level0 %b exp 010 0", j, tick, level[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        write_cfg(2'd1, 1'b1, 32'd1, 32'd1);
        write_cfg(2'd0, 1'b1, 32'd3, 32'd10);
        write_cfg(2'd0, 1'b1, 32'd1, 32'd2);    // last write to ch0 wins
        checks++; if (active !== 3'b011) begin errors++; $display("FAIL b2b_active got %b exp 011", active); end
        for (int j = 1; j <= 6; j++) begin
            idle();
            checks++;
            if (tick[0] !== ((j % 2) == 0)) begin
                errors++; $display("FAIL b2b_tick j=%0d got %b exp %b", j, tick[0], ((j % 2) == 0));
            end
        end
    endtask

    task automatic test_inc_eq_mod();
        do_reset();
        write_cfg(2'd2, 1'b1, 32'd7, 32'd7);
        for (int j = 1; j <= 6; j++) begin
            idle();
            checks++;
            if (tick[2] !== 1'b1 || level[2] !== ((j % 2) == 1)) begin
                errors++; $display("FAIL eq_tick_level j=%0d got %b %b exp 1 %b", j, tick[2], level[2], ((j % 2) == 1));
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_fractional();
        test_baud();
        test_rtc();
        test_errors();
        test_collision();
        test_back_to_back();
        test_inc_eq_mod();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout simulation exceeded 1000000 time units");
        $fatal(1);
    end

endmodule
